// File: rtl/apb_multi_slave_checker.sv
// Passive APB3/APB4 protocol checker: sticky per-rule error flags and saturating transfer counters.
// Define APB_CHK_STRB_EN to add the pstrb port, strobe hold/compare and the E5 strobe rule.
module apb_multi_slave_checker #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int NSLV     = 4,
  parameter int MAX_WAIT = 16,
  parameter int CNT_W    = 16
) (
  input  logic              pclk,
  input  logic              preset,
  input  logic [NSLV-1:0]   psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
`ifdef APB_CHK_STRB_EN
  input  logic [DATA_W/8-1:0] pstrb,
`endif
  input  logic              pready,
  input  logic              pslverr,
  input  logic              err_clr,
  output logic [5:0]        err_flags,
  output logic              err_pulse,
  output logic [2:0]        first_err,
  output logic [CNT_W-1:0]  wr_cnt,
  output logic [CNT_W-1:0]  rd_cnt,
  output logic [CNT_W-1:0]  slverr_cnt
);

  typedef enum logic [1:0] {S_IDLE, S_SETUP, S_WAIT, S_DONE} state_t;

  state_t            state, state_next;
  logic [7:0]        wait_cnt;
  logic [NSLV-1:0]   hold_psel;
  logic              hold_pwrite;
  logic [ADDR_W-1:0] hold_paddr;
  logic [DATA_W-1:0] hold_pwdata;
`ifdef APB_CHK_STRB_EN
  logic [DATA_W/8-1:0] hold_pstrb;
`endif

  logic       is_idle, is_setup, is_access, in_xfer, complete, held_diff;
  logic [5:0] viol;
  logic [2:0] viol_code;

  always_comb begin
    is_idle    = (psel == '0);
    is_setup   = !is_idle && !penable;
    is_access  = !is_idle && penable;
    in_xfer    = (state == S_SETUP) || (state == S_WAIT);
    complete   = is_access && pready && in_xfer;
    state_next = state;
    if (is_idle)       state_next = S_IDLE;
    else if (is_setup) state_next = S_SETUP;
    else if (!pready)  state_next = S_WAIT;
    else               state_next = S_DONE;

    held_diff = (psel != hold_psel) || (pwrite != hold_pwrite) || (paddr != hold_paddr) ||
                (hold_pwrite && (pwdata != hold_pwdata));
`ifdef APB_CHK_STRB_EN
    held_diff = held_diff || (pstrb != hold_pstrb);
`endif

    viol    = '0;
    viol[0] = |(psel & (psel - NSLV'(1)));
    viol[1] = (penable && is_idle) ||
              (is_access && ((state == S_IDLE) || (state == S_DONE))) ||
              (is_setup && (state == S_SETUP));
    viol[2] = in_xfer && is_access && held_diff;
    viol[3] = in_xfer && (is_idle || is_setup);
    // The counter only passes MAX_WAIT-1 once per transfer, so E4 fires once.
    viol[4] = is_access && !pready && (wait_cnt == 8'(MAX_WAIT - 1));
`ifdef APB_CHK_STRB_EN
    viol[5] = is_access && (pwrite ? (pstrb == '0) : (pstrb != '0));
`else
    viol[5] = 1'b0;
`endif

    viol_code = 3'd7;
    for (int i = 5; i >= 0; i--) begin
      if (viol[i]) viol_code = 3'(i);
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wait_cnt    <= '0;
      hold_psel   <= '0;
      hold_pwrite <= 1'b0;
      hold_paddr  <= '0;
      hold_pwdata <= '0;
`ifdef APB_CHK_STRB_EN
      hold_pstrb  <= '0;
`endif
    end else if (is_setup) begin
      wait_cnt    <= '0;
      hold_psel   <= psel;
      hold_pwrite <= pwrite;
      hold_paddr  <= paddr;
      hold_pwdata <= pwdata;
`ifdef APB_CHK_STRB_EN
      hold_pstrb  <= pstrb;
`endif
    end else if (is_access && !pready && (wait_cnt != 8'hFF)) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // A violation on the same edge as err_clr wins over the clear.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      err_flags <= '0;
      err_pulse <= 1'b0;
      first_err <= 3'd7;
    end else begin
      err_pulse <= |viol;
      if (err_clr) begin
        err_flags <= viol;
        first_err <= viol_code;
      end else begin
        err_flags <= err_flags | viol;
        if ((first_err == 3'd7) && (|viol)) first_err <= viol_code;
      end
    end
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      wr_cnt     <= '0;
      rd_cnt     <= '0;
      slverr_cnt <= '0;
    end else if (complete) begin
      if (hold_pwrite && !(&wr_cnt))  wr_cnt <= wr_cnt + CNT_W'(1);
      if (!hold_pwrite && !(&rd_cnt)) rd_cnt <= rd_cnt + CNT_W'(1);
      if (pslverr && !(&slverr_cnt))  slverr_cnt <= slverr_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_apb_multi_slave_checker.sv
// Directed self-checking bench for apb_multi_slave_checker (MAX_WAIT=4, CNT_W=2 to reach saturation).
// The E5 strobe steps are built only when APB_CHK_STRB_EN is defined.
module tb_apb_multi_slave_checker;

  logic        pclk = 1'b0;
  logic        preset;
  logic [3:0]  psel;
  logic        penable, pwrite, pready, pslverr, err_clr;
  logic [15:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  strb;
  logic [5:0]  err_flags;
  logic        err_pulse;
  logic [2:0]  first_err;
  logic [1:0]  wr_cnt, rd_cnt, slverr_cnt;

  int checks = 0;
  int errors = 0;

  apb_multi_slave_checker #(
    .ADDR_W(16), .DATA_W(32), .NSLV(4), .MAX_WAIT(4), .CNT_W(2)
  ) dut (
    .pclk(pclk), .preset(preset), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
`ifdef APB_CHK_STRB_EN
    .pstrb(strb),
`endif
    .pready(pready), .pslverr(pslverr), .err_clr(err_clr),
    .err_flags(err_flags), .err_pulse(err_pulse), .first_err(first_err),
    .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .slverr_cnt(slverr_cnt)
  );

  always #5 pclk = ~pclk;

  // Drive one bus sample, let the rising edge take it, then settle 1 time unit past the edge.
  task automatic apply_stimulus(input logic [3:0] sel, input logic en, input logic wr,
                                input logic [15:0] addr, input logic [31:0] data,
                                input logic rdy, input logic serr, input logic clr,
                                input logic [3:0] sb);
    psel = sel; penable = en; pwrite = wr; paddr = addr; pwdata = data;
    pready = rdy; pslverr = serr; err_clr = clr; strb = sb;
    @(posedge pclk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    preset = 1'b1;
    psel = '0; penable = 0; pwrite = 0; paddr = '0; pwdata = '0;
    pready = 0; pslverr = 0; err_clr = 0; strb = '0;
    repeat (2) @(posedge pclk);
    #1;
    check_output("reset_flags", 32'(err_flags), 32'h0);
    check_output("reset_first", 32'(first_err), 32'h7);
    check_output("reset_pulse", 32'(err_pulse), 32'h0);
    check_output("reset_wr", 32'(wr_cnt), 32'h0);
    preset = 1'b0;

    $display("[TB] write with one wait state");
    apply_stimulus(4'b0001, 0, 1, 16'h0010, 32'hA5A5A5A5, 0, 0, 0, 4'hF);
    apply_stimulus(4'b0001, 1, 1, 16'h0010, 32'hA5A5A5A5, 0, 0, 0, 4'hF);
    check_output("wr1_wait_cnt", 32'(wr_cnt), 32'h0);
    apply_stimulus(4'b0001, 1, 1, 16'h0010, 32'hA5A5A5A5, 1, 0, 0, 4'hF);
    check_output("wr1_cnt", 32'(wr_cnt), 32'h1);
    check_output("wr1_flags", 32'(err_flags), 32'h0);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);

    $display("[TB] two selects at once");
    apply_stimulus(4'b0011, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);
    check_output("e0_flags", 32'(err_flags), 32'h01);
    check_output("e0_first", 32'(first_err), 32'h0);
    check_output("e0_pulse", 32'(err_pulse), 32'h1);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);
    check_output("e0_abort_flags", 32'(err_flags), 32'h09);
    check_output("e0_first_kept", 32'(first_err), 32'h0);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 1, 4'h0);
    check_output("clr1_flags", 32'(err_flags), 32'h0);
    check_output("clr1_first", 32'(first_err), 32'h7);
    check_output("clr1_pulse", 32'(err_pulse), 32'h0);

    $display("[TB] setup held two cycles");
    apply_stimulus(4'b0010, 0, 1, 16'h0030, 32'h12345678, 0, 0, 0, 4'hF);
    check_output("setup1_flags", 32'(err_flags), 32'h0);
    apply_stimulus(4'b0010, 0, 1, 16'h0030, 32'h12345678, 0, 0, 0, 4'hF);
    check_output("setup2_flags", 32'(err_flags), 32'h0A);
    check_output("setup2_first", 32'(first_err), 32'h1);
    apply_stimulus(4'b0010, 1, 1, 16'h0030, 32'h12345678, 1, 0, 0, 4'hF);
    check_output("wr2_cnt", 32'(wr_cnt), 32'h2);
    check_output("wr2_pulse", 32'(err_pulse), 32'h0);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b0100, 0, 0, 16'h0040, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b0100, 1, 0, 16'h0040, 32'h0, 1, 1, 0, 4'h0);
    check_output("rd1_cnt", 32'(rd_cnt), 32'h1);
    check_output("slverr1_cnt", 32'(slverr_cnt), 32'h1);
    check_output("rd1_flags", 32'(err_flags), 32'h0A);

    $display("[TB] address changes during wait");
    apply_stimulus(4'b1000, 0, 0, 16'h0020, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b1000, 1, 0, 16'h0020, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b1000, 1, 0, 16'h0024, 32'h0, 0, 0, 0, 4'h0);
    check_output("e2_flags", 32'(err_flags), 32'h0E);
    check_output("e2_first", 32'(first_err), 32'h1);
    apply_stimulus(4'b1000, 1, 0, 16'h0020, 32'h0, 1, 0, 0, 4'h0);
    check_output("rd2_cnt", 32'(rd_cnt), 32'h2);
    check_output("rd2_slverr", 32'(slverr_cnt), 32'h1);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 1, 4'h0);
    check_output("clr2_flags", 32'(err_flags), 32'h0);
    check_output("clr2_first", 32'(first_err), 32'h7);

    $display("[TB] pready low for six cycles, then abort");
    apply_stimulus(4'b0001, 0, 1, 16'h0050, 32'h0BADF00D, 0, 0, 0, 4'hF);
    for (int i = 1; i <= 6; i++) begin
      apply_stimulus(4'b0001, 1, 1, 16'h0050, 32'h0BADF00D, 0, 0, 0, 4'hF);
      check_output($sformatf("wait%0d_flags", i), 32'(err_flags), (i >= 4) ? 32'h10 : 32'h0);
      check_output($sformatf("wait%0d_pulse", i), 32'(err_pulse), (i == 4) ? 32'h1 : 32'h0);
    end
    check_output("e4_first", 32'(first_err), 32'h4);
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);
    check_output("e3_flags", 32'(err_flags), 32'h18);
    check_output("e3_first", 32'(first_err), 32'h4);
    check_output("e3_wr_cnt", 32'(wr_cnt), 32'h2);

    $display("[TB] back-to-back writes into saturation");
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 1, 4'h0);
    apply_stimulus(4'b0010, 0, 1, 16'h0060, 32'h11111111, 0, 0, 0, 4'hF);
    apply_stimulus(4'b0010, 1, 1, 16'h0060, 32'h11111111, 1, 0, 0, 4'hF);
    check_output("wr3_cnt", 32'(wr_cnt), 32'h3);
    apply_stimulus(4'b0010, 0, 1, 16'h0064, 32'h22222222, 0, 0, 0, 4'hF);
    apply_stimulus(4'b0010, 1, 1, 16'h0064, 32'h22222222, 1, 0, 0, 4'hF);
    check_output("wr_sat_cnt", 32'(wr_cnt), 32'h3);
    check_output("b2b_flags", 32'(err_flags), 32'h0);

`ifdef APB_CHK_STRB_EN
    $display("[TB] read with strobes set");
    apply_stimulus(4'b0000, 0, 0, 16'h0000, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b0001, 0, 0, 16'h0070, 32'h0, 0, 0, 0, 4'hF);
    apply_stimulus(4'b0001, 1, 0, 16'h0070, 32'h0, 1, 0, 0, 4'hF);
    check_output("e5_flags", 32'(err_flags), 32'h20);
    check_output("e5_first", 32'(first_err), 32'h5);
`endif

    $display("[TB] reset in the middle of an access");
    apply_stimulus(4'b0100, 0, 0, 16'h0080, 32'h0, 0, 0, 0, 4'h0);
    apply_stimulus(4'b0100, 1, 0, 16'h0080, 32'h0, 0, 0, 0, 4'h0);
    preset = 1'b1;
    #2;
    check_output("rst_flags", 32'(err_flags), 32'h0);
    check_output("rst_first", 32'(first_err), 32'h7);
    check_output("rst_wr", 32'(wr_cnt), 32'h0);
    check_output("rst_rd", 32'(rd_cnt), 32'h0);
    check_output("rst_slverr", 32'(slverr_cnt), 32'h0);
    #2;
    preset = 1'b0;
    apply_stimulus(4'b0100, 1, 0, 16'h0080, 32'h0, 1, 0, 0, 4'h0);
    check_output("post_rst_flags", 32'(err_flags), 32'h02);
    check_output("post_rst_first", 32'(first_err), 32'h1);
    check_output("post_rst_rd", 32'(rd_cnt), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
